uart_duplex: RTL

- Parametrised full-duplex UART core; next generation of the fixed 8N1 rx/tx pair.
- Configurable clock/baud, data width and stop bits; optional parity.
- Valid/ready handshakes on both byte interfaces; RX holding register; sticky error flags.
- Instantiated by the chip top in place of the separate fixed receive and transmit blocks.

---
 rtl/uart_duplex_if.sv | 21 ++
 rtl/uart_duplex.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_duplex_if.sv
// Byte-side handshake bundle for uart_duplex: TX write channel and RX read channel.
interface uart_duplex_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/uart_duplex.sv
// Parametrised full-duplex UART core with valid/ready byte channels,
// RX holding register and sticky error flags.
// Optional parity bit enabled by defining UART_PARITY_EN.
module uart_duplex #(
  parameter int unsigned CLK_HZ     = 5_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic         clock,
  input  logic         reset_n,
  uart_duplex_if.slave bus,
  output logic         tx,
  input  logic         rx,
  output logic         frame_err,
  output logic         overrun,
  output logic         parity_err,
  input  logic         err_clear
);

  localparam int unsigned DIV = CLK_HZ / BAUD;
  localparam int unsigned CW  = $clog2(DIV);
  localparam int unsigned BW  = $clog2(DATA_BITS + 1);

  // Reject parameter sets the datapath cannot represent.
  if (DIV < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_duplex: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // ---------------------------------------------------------------- TX
  state_t               tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_bit;
  logic [DATA_BITS-1:0] tx_shreg;
  logic                 tx_rdy;
  logic                 tx_tick;
`ifdef UART_PARITY_EN
  logic                 tx_par;
`endif

  assign tx_tick      = (tx_cnt == CW'(DIV - 1));
  assign bus.tx_ready = tx_rdy;

  // Transmit FSM: start bit, LSB-first data, optional parity, stop bits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shreg <= '0;
      tx_rdy   <= 1'b1;
      tx       <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      case (tx_state)
        S_IDLE: begin
          if (bus.tx_valid) begin
            tx_shreg <= bus.tx_data;
            tx_rdy   <= 1'b0;
            tx       <= 1'b0;
            tx_cnt   <= '0;
            tx_state <= S_START;
`ifdef UART_PARITY_EN
            tx_par   <= (^bus.tx_data) ^ 1'(PARITY_ODD);
`endif
          end
        end
        S_START: begin
          if (tx_tick) begin
            tx_cnt   <= '0;
            tx       <= tx_shreg[0];
            tx_shreg <= tx_shreg >> 1;
            tx_bit   <= '0;
            tx_state <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (tx_tick) begin
            tx_cnt <= '0;
            if (tx_bit == BW'(DATA_BITS - 1)) begin
              tx_bit   <= '0;
`ifdef UART_PARITY_EN
              tx       <= tx_par;
              tx_state <= S_PARITY;
`else
              tx       <= 1'b1;
              tx_state <= S_STOP;
`endif
            end else begin
              tx       <= tx_shreg[0];
              tx_shreg <= tx_shreg >> 1;
              tx_bit   <= tx_bit + BW'(1);
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
`ifdef UART_PARITY_EN
        S_PARITY: begin
          if (tx_tick) begin
            tx_cnt   <= '0;
            tx       <= 1'b1;
            tx_state <= S_STOP;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
`endif
        S_STOP: begin
          if (tx_tick) begin
            tx_cnt <= '0;
            if (tx_bit == BW'(STOP_BITS - 1)) begin
              tx_bit   <= '0;
              tx_rdy   <= 1'b1;
              tx_state <= S_IDLE;
            end else begin
              tx_bit <= tx_bit + BW'(1);
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        default: begin
          tx_state <= S_IDLE;
          tx       <= 1'b1;
          tx_rdy   <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- RX
  logic                 rx_meta;
  logic                 rx_s;
  state_t               rx_state;
  logic [CW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_bit;
  logic [DATA_BITS-1:0] rx_shreg;
  logic [DATA_BITS-1:0] rx_dat;
  logic                 rx_vld;
  logic                 rx_tick;
  logic                 stop_sample;
  logic                 fe_set;
  logic                 ov_set;

  assign rx_tick      = (rx_cnt == CW'(DIV - 1));
  assign stop_sample  = (rx_state == S_STOP) && rx_tick;
  assign fe_set       = stop_sample && !rx_s;
  assign ov_set       = stop_sample && rx_vld && !bus.rx_ready;
  assign bus.rx_data  = rx_dat;
  assign bus.rx_valid = rx_vld;

  // Two-flop synchroniser for the asynchronous serial input; idles high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Receive FSM: mid-bit sampling, false-start rejection, early exit after stop sample.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shreg <= '0;
    end else begin
      case (rx_state)
        S_IDLE: begin
          if (!rx_s) begin
            rx_cnt   <= '0;
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt == CW'(DIV / 2)) begin
            rx_cnt <= '0;
            if (rx_s) begin
              rx_state <= S_IDLE;
            end else begin
              rx_bit   <= '0;
              rx_state <= S_DATA;
            end
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (rx_tick) begin
            rx_cnt   <= '0;
            rx_shreg <= {rx_s, rx_shreg[DATA_BITS-1:1]};
            if (rx_bit == BW'(DATA_BITS - 1)) begin
              rx_bit   <= '0;
`ifdef UART_PARITY_EN
              rx_state <= S_PARITY;
`else
              rx_state <= S_STOP;
`endif
            end else begin
              rx_bit <= rx_bit + BW'(1);
            end
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
`ifdef UART_PARITY_EN
        S_PARITY: begin
          if (rx_tick) begin
            rx_cnt   <= '0;
            rx_state <= S_STOP;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
`endif
        S_STOP: begin
          if (rx_tick) begin
            rx_cnt   <= '0;
            rx_state <= S_IDLE;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  // Holding register: load on frame completion unless an unread byte is kept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_dat <= '0;
      rx_vld <= 1'b0;
    end else if (stop_sample) begin
      if (!rx_vld || bus.rx_ready) begin
        rx_dat <= rx_shreg;
        rx_vld <= 1'b1;
      end
    end else if (rx_vld && bus.rx_ready) begin
      rx_vld <= 1'b0;
    end
  end

  // Sticky flags; a coincident set beats err_clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= fe_set | (frame_err & ~err_clear);
      overrun   <= ov_set | (overrun & ~err_clear);
    end
  end

`ifdef UART_PARITY_EN
  logic pe_set;
  assign pe_set = (rx_state == S_PARITY) && rx_tick &&
                  (rx_s != ((^rx_shreg) ^ 1'(PARITY_ODD)));

  // Sticky parity flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= pe_set | (parity_err & ~err_clear);
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
